// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer_pkg / store_buffer
//
// Posted-write buffer between the pipeline memory stage and DataMemory.
// Stores are accepted in a single cycle and queued in a DEPTH-entry FIFO.
// They drain to the single DataMemory port in any cycle that a load has not
// claimed the port. A load whose word address matches any queued store is
// stalled until that store has drained, so loads only ever see committed data.
//
// Ports
//   iClk, iRstN            clock (rising edge) / async active-low reset
//   iStoreValid/Type/Addr/Data, oStoreReady   store push side
//   iLoadValid, iLoadAddr, oLoadStall         load hazard check
//   iMemBusy                                  port claimed by a load this cycle
//   oMemWriteEn/Type/Address/Data             drain side to DataMemory
//   oEmpty                                    no queued stores (FENCE / halt)
// -----------------------------------------------------------------------------
package store_buffer_pkg;

  typedef enum logic [1:0] {
    SUB_NONE   = 2'd0,
    STORE_BYTE = 2'd1,
    STORE_HALF = 2'd2,
    STORE_WORD = 2'd3
  } InstructionSubTypes;

endpackage

module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  input  logic                  iStoreValid,
  input  InstructionSubTypes    iStoreType,
  input  logic [31:0]           iStoreAddr,
  input  logic [DATA_WIDTH-1:0] iStoreData,
  output logic                  oStoreReady,
  input  logic                  iLoadValid,
  input  logic [31:0]           iLoadAddr,
  output logic                  oLoadStall,
  input  logic                  iMemBusy,
  output logic                  oMemWriteEn,
  output InstructionSubTypes    oMemType,
  output logic [31:0]           oMemAddress,
  output logic [DATA_WIDTH-1:0] oMemData,
  output logic                  oEmpty
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_ZERO = '0;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  InstructionSubTypes    entry_type [DEPTH];
  logic [31:0]           entry_addr [DEPTH];
  logic [DATA_WIDTH-1:0] entry_data [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic push;
  logic drain;
  logic empty;
  logic hit;

  // Byte offset within the word plays no part in the hazard check.
  logic unused_load_lsb;
  assign unused_load_lsb = ^iLoadAddr[1:0];

  assign empty       = (count == CNT_ZERO);
  assign oEmpty      = empty;
  // Ready looks only at registered count, keeping iMemBusy off the push path.
  assign oStoreReady = (count != CNT_FULL);
  assign push        = iStoreValid && oStoreReady;
  assign drain       = !empty && !iMemBusy;
  assign oMemWriteEn = drain;

  assign oMemType    = empty ? SUB_NONE : entry_type[head];
  assign oMemAddress = empty ? '0       : entry_addr[head];
  assign oMemData    = empty ? '0       : entry_data[head];

  // An entry is live when its distance from head is below count. Only
  // registered entries are compared, so a same-cycle push never stalls
  // a load, while an entry draining this cycle still does.
  always_comb begin
    logic [PTR_W-1:0] offset;
    hit    = 1'b0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - head;
      if (({1'b0, offset} < count) && (entry_addr[i][31:2] == iLoadAddr[31:2])) begin
        hit = 1'b1;
      end
    end
  end

  assign oLoadStall = iLoadValid && hit;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_type[i] <= SUB_NONE;
        entry_addr[i] <= '0;
        entry_data[i] <= '0;
      end
    end else begin
      if (push) begin
        entry_type[tail] <= iStoreType;
        entry_addr[tail] <= iStoreAddr;
        entry_data[tail] <= iStoreData;
        tail             <= tail + PTR_ONE;
      end
      if (drain) begin
        head <= head + PTR_ONE;
      end
      case ({push, drain})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the pipeline's memory stage and DataMemory. Stores are accepted in one cycle and queued in a DEPTH-entry FIFO, then drained to DataMemory's single port in cycles the port is not needed by a load. A load whose word address matches any queued store is stalled until that store has drained, so loads always read committed data.

## Interface
- DEPTH, default 4: FIFO entries; power of two, ≥ 2.
- DATA_WIDTH, default 32: store data width.

- iClk  in  1  clock; all state updates on rising edge.
- iRstN  in  1  asynchronous active-low reset.
- iStoreValid  in  1  store request from memory stage.
- iStoreType  in  InstructionSubTypes  STORE_BYTE / STORE_HALF / STORE_WORD.
- iStoreAddr  in  32  byte address of store.
- iStoreData  in  DATA_WIDTH  store data, unshifted (byte/half in low bits).
- oStoreReady  out  1  buffer can accept a store this cycle.
- iLoadValid  in  1  load request from memory stage.
- iLoadAddr  in  32  byte address of load.
- oLoadStall  out  1  load word-address hits a queued store; pipeline must hold.
- iMemBusy  in  1  DataMemory port claimed by a load this cycle.
- oMemWriteEn  out  1  write strobe to DataMemory (iWriteEn).
- oMemType  out  InstructionSubTypes  to iMemoryInstructionType.
- oMemAddress  out  32  to iAddress.
- oMemData  out  DATA_WIDTH  to iMemData.
- oEmpty  out  1  no queued stores (used by FENCE / halt).

## Operation
- Storage: DEPTH entries of {type, addr[31:0], data}; head pointer, tail pointer (log2(DEPTH) bits, wrap modulo DEPTH), count (log2(DEPTH)+1 bits, 0..DEPTH).
- Push: iStoreValid && oStoreReady → entry written at tail, tail+1, count+1. iStoreValid while !oStoreReady: ignored, no state change; the pipeline must hold the request.
- oStoreReady = (count != DEPTH). Does not depend on same-cycle drain, so no combinational path from iMemBusy.
- Drain: oMemWriteEn = (count != 0) && !iMemBusy. oMemType/oMemAddress/oMemData = head entry (zero when empty). When oMemWriteEn is high, head+1, count−1 at the clock edge.
- Simultaneous push and drain: count unchanged, both pointers advance.
- Type and address are replayed verbatim; the buffer does no alignment, shifting or merging. Misaligned stores pass through unchanged.
- Load hazard: oLoadStall = iLoadValid && (any valid entry with addr[31:2] == iLoadAddr[31:2]). Sizes are ignored: any same-word overlap stalls. An entry draining this cycle still counts as valid for the check; the stall clears the following cycle.
- iLoadValid and iStoreValid both high: the store is processed normally, and the load is checked against pre-push entries only.
- oEmpty = (count == 0).

## Timing
- Reset (iRstN low, async): head = tail = count = 0; oStoreReady = 1, oEmpty = 1, oMemWriteEn = 0, oLoadStall = 0, oMemAddress/oMemData = 0. All queued stores are discarded. Release is synchronous to the next rising edge.
- Store-to-memory latency: a store pushed at edge N reaches the DataMemory port at cycle N+1, when the buffer was empty and iMemBusy = 0.
- Sustained throughput: one push and one drain per cycle.
- oStoreReady, oEmpty and the mem-side data fields are functions of registered state only. oMemWriteEn and oLoadStall are combinational from iMemBusy / iLoadValid / iLoadAddr plus state.
- Full: after DEPTH pushes with no drain, oStoreReady = 0 until the first drain edge, then rises the next cycle.

## Test plan
- Reset mid-operation: push 3 stores, assert iRstN low between edges → oEmpty = 1 and oMemWriteEn = 0 immediately; no write appears after release.
- Single store: STORE_WORD addr 0x100 data 0xDEADBEEF, iMemBusy = 0 → next cycle oMemWriteEn = 1, oMemAddress = 0x100, oMemData = 0xDEADBEEF, oMemType = STORE_WORD; oEmpty = 1 after that edge.
- Fill and wrap: iMemBusy = 1, push 4 stores (0x0, 0x4, 0x8, 0xC) → oStoreReady = 0 and a 5th push is ignored. Release busy → 4 writes drain in order. Push 4 more across the pointer wrap → order preserved.
- Load hazard: queue STORE_BYTE at 0x203, iMemBusy = 1, load 0x200 → oLoadStall = 1. Load 0x204 → oLoadStall = 0. Drop busy → the store drains, and oLoadStall for 0x200 clears the next cycle.
- Simultaneous push + drain at count = 2 → count stays 2, with correct head and tail order over 10 back-to-back stores.
- Type passthrough: STORE_HALF addr 0x302 data 0x0000ABCD → oMemType = STORE_HALF, oMemAddress = 0x302, oMemData = 0x0000ABCD, unmodified.
